// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the router arbitration blocks.
// Holds the packet-arbiter state encoding and the weight normalisation rule.
package arbiter_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  // A zero weight would starve the agent's own burst, so it is treated as 1.
  function automatic int unsigned weight_eff(input int unsigned weight);
    return (weight == 0) ? 1 : weight;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after start, wrapping.
// Reusable by any allocator that keeps its own priority pointer.
module rr_priority_picker #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     requests,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // NOTE: every output and temporary gets a default first so no latch is inferred.
  always_comb begin
    grant   = '0;
    valid   = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < N; k++) begin
      // Wrap by compare-and-subtract instead of a modulo divider.
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = pos[IDX_W-1:0];
      if (!valid && requests[pos_idx]) begin
        valid          = 1'b1;
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
      end
    end
  end

endmodule

// File: rtl/weighted_rr_packet_arbiter.sv
// Weighted round-robin packet arbiter: holds a grant head-to-tail and lets an
// agent win up to its weight in consecutive packets before priority rotates.
module weighted_rr_packet_arbiter
  import arbiter_pkg::*;
#(
  parameter  int AGENTS_NUM = 4,
  parameter  int WEIGHT_W   = 4,
  parameter  bit LOCK_EN    = 1'b1,
  localparam int IDX_W      = $clog2(AGENTS_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [AGENTS_NUM-1:0]          requests_i,
  input  logic [AGENTS_NUM-1:0]          tail_i,
  input  logic [AGENTS_NUM*WEIGHT_W-1:0] weights_i,
  input  logic                           ack_i,
  output logic [AGENTS_NUM-1:0]          grants_o,
  output logic                           grant_valid_o,
  output logic [IDX_W-1:0]               grant_idx_o
);

  arb_state_t         state_q, state_n;
  logic [IDX_W-1:0]   ptr_q, ptr_n;
  logic [IDX_W-1:0]   owner_q, owner_n;
  logic [WEIGHT_W-1:0] served_q, served_n;

  logic [AGENTS_NUM-1:0] pick_grant;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;

  logic                  accept;
  logic                  pkt_done;
  int unsigned           served_next;
  int unsigned           weff;

  rr_priority_picker #(.N(AGENTS_NUM)) u_picker (
    .requests (requests_i),
    .start    (ptr_q),
    .grant    (pick_grant),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      served_q <= '0;
    end else begin
      state_q  <= state_n;
      ptr_q    <= ptr_n;
      owner_q  <= owner_n;
      served_q <= served_n;
    end
  end

  // Grant is forced low during reset even though state is already cleared.
  always_comb begin
    grants_o    = '0;
    grant_idx_o = '0;
    if (!rst) begin
      if (state_q == LOCKED) begin
        if (requests_i[owner_q]) begin
          grants_o[owner_q] = 1'b1;
          grant_idx_o       = owner_q;
        end
      end else if (pick_valid) begin
        grants_o    = pick_grant;
        grant_idx_o = pick_idx;
      end
    end
  end

  assign grant_valid_o = |grants_o;
  assign accept        = ack_i && grant_valid_o;

  always_comb begin
    state_n     = state_q;
    ptr_n       = ptr_q;
    owner_n     = owner_q;
    served_n    = served_q;
    pkt_done    = 1'b0;
    served_next = 0;
    weff        = 1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LOCK_EN && !tail_i[grant_idx_o]) begin
            state_n = LOCKED;
            owner_n = grant_idx_o;
          end else begin
            pkt_done = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (accept && tail_i[owner_q]) begin
          state_n  = IDLE;
          pkt_done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // The weight is read at packet end, so a mid-burst change applies here.
    if (pkt_done) begin
      served_next = (grant_idx_o == ptr_q) ? int'(served_q) + 1 : 1;
      weff        = weight_eff(32'(weights_i[grant_idx_o*WEIGHT_W +: WEIGHT_W]));
      if (served_next >= weff) begin
        ptr_n    = (int'(grant_idx_o) == AGENTS_NUM - 1) ? '0 : grant_idx_o + IDX_W'(1);
        served_n = '0;
      end else begin
        ptr_n    = grant_idx_o;
        served_n = served_next[WEIGHT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_weighted_rr_packet_arbiter.sv
// Directed self-checking bench for weighted_rr_packet_arbiter (N=4, W=4, locking on).
module tb_weighted_rr_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  requests;
  logic [3:0]  tail;
  logic [15:0] weights;
  logic        ack;
  logic [3:0]  grants;
  logic        grant_valid;
  logic [1:0]  grant_idx;

  int checks   = 0;
  int failures = 0;

  weighted_rr_packet_arbiter #(
    .AGENTS_NUM (4),
    .WEIGHT_W   (4),
    .LOCK_EN    (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .requests_i    (requests),
    .tail_i        (tail),
    .weights_i     (weights),
    .ack_i         (ack),
    .grants_o      (grants),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after inputs change, mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; requests = 4'b1111; tail = 4'b1111; ack = 1'b1; weights = 16'h1111;
    #1;
    checks++;
    if (grants !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: got grants=%b valid=%b idx=%0d expected 0000/0/0",
               grants, grant_valid, grant_idx);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (grants !== 4'b0001 || grant_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_grant: got grants=%b idx=%0d expected 0001/0", grants, grant_idx);
    end
  endtask

  task automatic test_basic_rr();
    logic [3:0] exp;
    do_reset();
    weights = 16'h1111; tail = 4'b1111; ack = 1'b1; requests = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp = 4'b0001 << (i % 4);
      checks++;
      if (grants !== exp || grant_idx !== 2'(i % 4) || grant_valid !== 1'b1) begin
        failures++;
        $display("FAIL basic_rr[%0d]: got grants=%b idx=%0d expected %b/%0d",
                 i, grants, grant_idx, exp, i % 4);
      end
      next_cycle();
    end
  endtask

  task automatic test_zero_weight();
    do_reset();
    weights = 16'h0000; tail = 4'b1111; ack = 1'b1; requests = 4'b1111;
    #1;
    checks++;
    if (grants !== 4'b0001) begin
      failures++;
      $display("FAIL zero_weight_a: got %b expected 0001", grants);
    end
    next_cycle();
    checks++;
    if (grants !== 4'b0010) begin
      failures++;
      $display("FAIL zero_weight_b: got %b expected 0010", grants);
    end
  endtask

  task automatic test_weighted();
    logic [3:0] exp [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b1000};
    do_reset();
    weights = 16'h3111; tail = 4'b1111; ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      requests = (i == 0) ? 4'b1000 : 4'b1001;
      #1;
      checks++;
      if (grants !== exp[i]) begin
        failures++;
        $display("FAIL weighted[%0d]: got %b expected %b", i, grants, exp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    weights = 16'h1111; ack = 1'b1; requests = 4'b0110;
    for (int f = 0; f < 4; f++) begin
      tail = (f == 3) ? 4'b0110 : 4'b0100;
      #1;
      checks++;
      if (grants !== 4'b0010) begin
        failures++;
        $display("FAIL lock_flit[%0d]: got %b expected 0010", f, grants);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (grants !== 4'b0100 || grant_idx !== 2'd2) begin
      failures++;
      $display("FAIL lock_after_tail: got grants=%b idx=%0d expected 0100/2", grants, grant_idx);
    end
  endtask

  task automatic test_owner_stall();
    do_reset();
    weights = 16'h1111; ack = 1'b1; tail = 4'b0100; requests = 4'b0110;
    next_cycle();
    requests = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (grants !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
        failures++;
        $display("FAIL stall[%0d]: got grants=%b valid=%b idx=%0d expected 0000/0/0",
                 c, grants, grant_valid, grant_idx);
      end
      next_cycle();
    end
    requests = 4'b0110;
    #1;
    checks++;
    if (grants !== 4'b0010) begin
      failures++;
      $display("FAIL stall_resume: got %b expected 0010", grants);
    end
    tail = 4'b0110;
    next_cycle();
    checks++;
    if (grants !== 4'b0100) begin
      failures++;
      $display("FAIL stall_release: got %b expected 0100", grants);
    end
  endtask

  task automatic test_ack_hold();
    do_reset();
    weights = 16'h1111; tail = 4'b1111; requests = 4'b0110; ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (grants !== 4'b0010) begin
        failures++;
        $display("FAIL ack_hold[%0d]: got %b expected 0010", c, grants);
      end
      next_cycle();
    end
    ack = 1'b1;
    next_cycle();
    ack = 1'b0;
    #1;
    checks++;
    if (grants !== 4'b0100) begin
      failures++;
      $display("FAIL ack_pulse: got %b expected 0100", grants);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    weights = 16'h1111; ack = 1'b1; tail = 4'b0000; requests = 4'b0100;
    next_cycle();
    requests = 4'b0101;
    #1;
    checks++;
    if (grants !== 4'b0100) begin
      failures++;
      $display("FAIL mid_lock: got %b expected 0100", grants);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (grants !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset: got grants=%b valid=%b idx=%0d expected 0000/0/0",
               grants, grant_valid, grant_idx);
    end
    next_cycle();
    rst = 1'b0;
    tail = 4'b1111;
    #1;
    checks++;
    if (grants !== 4'b0001) begin
      failures++;
      $display("FAIL post_reset: got %b expected 0001", grants);
    end
  endtask

  initial begin
    rst = 1'b1; requests = '0; tail = '0; weights = '0; ack = 1'b0;
    #2;
    test_reset();
    test_basic_rr();
    test_zero_weight();
    test_weighted();
    test_packet_lock();
    test_owner_stall();
    test_ack_hold();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weighted_rr_packet_arbiter.md
Name: weighted_rr_packet_arbiter

Overview:
- Parametrised N-way round-robin arbiter for router switch/VC allocation, successor to the single-flit round-robin arbiter.
- Adds per-agent integer weights: an agent may win up to W consecutive packets before priority rotates.
- Adds packet locking: a grant is held from head flit to tail flit.
- Pointer and weight state advance only on downstream acceptance (ack), never on a bare request.

Parameters:
- AGENTS_NUM, 4, number of requesters (>=2).
- WEIGHT_W, 4, bit width of each per-agent weight field.
- LOCK_EN, 1, 1 = hold grant until tail flit accepted; 0 = every accepted flit ends arbitration (tail_i ignored).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- requests_i  input  AGENTS_NUM  per-agent request.
- tail_i  input  AGENTS_NUM  per-agent flag: the presented flit is the last of its packet.
- weights_i  input  AGENTS_NUM*WEIGHT_W  per-agent weight, agent i in bits [i*WEIGHT_W +: WEIGHT_W]; quasi-static, may change between packets.
- ack_i  input  1  downstream accepted the granted flit this cycle.
- grants_o  output  AGENTS_NUM  one-hot or zero grant.
- grant_valid_o  output  1  OR of grants_o.
- grant_idx_o  output  $clog2(AGENTS_NUM)  index of the granted agent; 0 when there is no grant.

Behaviour:
- State: ptr (priority pointer), served_cnt (WEIGHT_W bits), FSM {IDLE, LOCKED}, owner index.
- Reset values: ptr=0, served_cnt=0, IDLE, owner=0.
- While rst is high, grants_o=0, grant_valid_o=0, grant_idx_o=0.
- Outputs are combinational from state and requests_i; zero-cycle request-to-grant latency.
- Effective weight: weff[i] = weights_i[i] if non-zero, else 1.
- IDLE grant: the first requester found scanning ptr, ptr+1, ... modulo AGENTS_NUM. No requester gives no grant.
- LOCKED grant: only owner is granted, and only while requests_i[owner]=1. Other requests are ignored. If the owner drops its request, grants_o=0 and the FSM stays LOCKED (stall).
- Accept event: ack_i=1 while grant_valid_o=1. ack_i without a grant is ignored, with no state change.
- IDLE accept on agent r:
  - If LOCK_EN=1 and tail_i[r]=0: go to LOCKED, owner=r.
  - Otherwise: packet done for r (single-flit packet).
- LOCKED accept with tail_i[owner]=1: packet done for owner, go to IDLE. A non-tail accept keeps LOCKED.
- Packet done for agent r:
  - s = (r==ptr) ? served_cnt+1 : 1.
  - If s >= weff[r]: ptr=(r+1) mod AGENTS_NUM, served_cnt=0.
  - Else: ptr=r, served_cnt=s.
- served_cnt compares are unsigned; served_cnt never exceeds weff-1.
- Pointer wrap: agent AGENTS_NUM-1 done with its weight exhausted gives ptr=0.
- Weight change mid-burst takes effect at the next packet-done compare. A weight lowered below served_cnt+1 rotates ptr on the next packet done.
- Simultaneous tail accept and new requests: the new winner is granted from the next cycle, using the updated ptr.
- Reset mid-packet aborts the lock; the next cycle after release is a fresh IDLE arbitration from agent 0.
- Equivalence: all weights 1, ack_i=1, all tail_i=1 gives the classic single-flit round-robin arbiter behaviour.
- Non-power-of-2 AGENTS_NUM is supported; the modulo is computed without a divider (compare and subtract).

Decomposition:
- Shared package arbiter_pkg: typedef arb_state_t {IDLE, LOCKED}; function weight_eff().
- Sub-module rr_priority_picker: purely combinational. Inputs are the request vector and start pointer; outputs are the one-hot grant, valid and index. It is reusable by other allocators in the design.

Test Plan:
1. N=4, weights all 1, tail=1, ack=1, requests=4'b1111 for 8 cycles -> grants 0001,0010,0100,1000,0001,... ; ptr wraps 3->0.
2. N=4, weights {1,1,1,3} (agent3=3), requests=4'b1000 then 4'b1001 -> agent3 wins 3 packets, then agent0, then agent3 again.
3. LOCK_EN=1, agent1 sends a 4-flit packet (tail on flit 4) while agent2 requests constantly -> grants_o=0010 for all 4 accepts, then 0100.
4. Locked owner drops its request for 2 cycles mid-packet -> grants_o=0 for those 2 cycles, agent2 not granted, lock resumes.
5. ack_i=0 for 3 cycles with requests=4'b0110 -> grant stays 0010 and ptr does not move; ack_i pulse -> next grant 0100.
6. rst asserted during LOCKED on agent2 -> outputs 0 immediately; after release with requests=4'b0101 -> grant 0001.
